// File: rtl/clk_div_sched.sv
`timescale 1ns/1ps
// Runtime-programmable integer clock divider; new ratios are taken over valid/ready
// and applied only at a period boundary. Define CLK_DIV_SCHED_PCNT_EN to add the pcnt period counter.
module clk_div_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 7,
    parameter int unsigned MIN_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic [CNT_W-1:0] div_cur,
    output logic             busy
`ifdef CLK_DIV_SCHED_PCNT_EN
    ,
    output logic [15:0]      pcnt
`endif
);

    localparam int unsigned PCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;
    logic             p_q, p_d;
    logic             n_q;

    logic [CNT_W-1:0] half_c;
    logic             run_c;
    logic             last_c;
    logic             bnd_c;
    logic             apply_c;
    logic             xfer_c;
    logic             legal_c;

    // ceil(N/2) without overflowing CNT_W at the top ratio
    assign half_c  = (div_cur_q >> 1) + CNT_W'(div_cur_q[0]);
    assign run_c   = (state_q != IDLE);
    assign last_c  = (cnt_q == div_cur_q - CNT_W'(1));
    assign bnd_c   = run_c & last_c;
    assign apply_c = pend_vld_q & (~run_c | last_c);
    assign xfer_c  = cfg_valid & ~pend_vld_q;
    assign legal_c = (cfg_div >= CNT_W'(MIN_DIV));

    // Next state, period counter, handshake and ratio apply
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = 1'b0;
        div_cur_d  = div_cur_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = 1'b0;

        if (xfer_c) begin
            if (legal_c) begin
                pend_div_d = cfg_div;
                pend_vld_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN, DRAIN: begin
                p_d = (cnt_q < half_c);
                if (state_q == RUN && !en) begin
                    state_d = DRAIN;
                end else if (state_q == DRAIN && en) begin
                    state_d = RUN;
                end
                if (last_c) begin
                    cnt_d = '0;
                    if (state_q == DRAIN && !en) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply_c) begin
            div_cur_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end

        cfg_ready_d = ~pend_vld_d;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= 1'b0;
            div_cur_q   <= CNT_W'(DEF_DIV);
            pend_div_q  <= '0;
            pend_vld_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            div_cur_q   <= div_cur_d;
            pend_div_q  <= pend_div_d;
            pend_vld_q  <= pend_vld_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
        end
    end

    // Half-cycle delayed copy of p; ANDing it in trims odd ratios to 50% duty
    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) n_q <= 1'b0;
        else      n_q <= p_q;
    end

    assign clk_out   = p_q & (n_q | ~div_cur_q[0]);
    assign div_cur   = div_cur_q;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

`ifdef CLK_DIV_SCHED_PCNT_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Completed periods since the last ratio change; wraps naturally
    always_comb begin
        pcnt_d = pcnt_q;
        if (bnd_c) pcnt_d = pcnt_q + PCNT_W'(1);
        if (apply_c) pcnt_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) pcnt_q <= '0;
        else      pcnt_q <= pcnt_d;
    end

    assign pcnt = pcnt_q;
`else
    logic unused_pcnt_c;
    assign unused_pcnt_c = bnd_c & (PCNT_W != 0);
`endif

endmodule
